// File: rtl/keypad_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_matrix_scanner_pkg
// Brief   : Shared key-code constants and helpers for the keypad scanner/decoder
// Revision: 1.0
// ============================================================================
package keypad_matrix_scanner_pkg;

    typedef logic [15:0] key_code_t;

    localparam key_code_t KEY_NONE = 16'h0000;

    // Onehot bit index per physical key: col*4 + row
    localparam int KEY_IDX_1    = 0;
    localparam int KEY_IDX_4    = 1;
    localparam int KEY_IDX_7    = 2;
    localparam int KEY_IDX_STAR = 3;
    localparam int KEY_IDX_2    = 4;
    localparam int KEY_IDX_5    = 5;
    localparam int KEY_IDX_8    = 6;
    localparam int KEY_IDX_0    = 7;
    localparam int KEY_IDX_3    = 8;
    localparam int KEY_IDX_6    = 9;
    localparam int KEY_IDX_9    = 10;
    localparam int KEY_IDX_HASH = 11;
    localparam int KEY_IDX_A    = 12;
    localparam int KEY_IDX_B    = 13;
    localparam int KEY_IDX_C    = 14;
    localparam int KEY_IDX_D    = 15;

    function automatic logic is_single_key(input key_code_t v);
        return (v != KEY_NONE) && ((v & (v - 16'd1)) == KEY_NONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_sync2.sv
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Parameterised-width two-flop synchroniser with reset value
// Revision: 1.0
// ============================================================================
module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_matrix_scanner
// Brief   : 4x4 active-low keypad scanner with frame debounce and onehot output
// Revision: 1.0
// ============================================================================
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] onehot,
    output logic        key_pulse
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_FRAMES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [STAB_W-1:0] STAB_ARM  = STAB_W'(DEBOUNCE_FRAMES - 2);

    logic [3:0]        w_row_sync;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_q, col_d;
    logic [3:0]        col_n_q, col_n_d;
    key_code_t         frame_q, frame_d;
    key_code_t         last_frame_q, last_frame_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    key_code_t         onehot_q, onehot_d;
    logic              pulse_q, pulse_d;
    key_code_t         w_full;
    key_code_t         w_commit;
    logic              w_sample;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_n),
        .q_o (w_row_sync)
    );

    always_comb begin
        slot_d       = slot_q;
        col_d        = col_q;
        col_n_d      = col_n_q;
        frame_d      = frame_q;
        last_frame_d = last_frame_q;
        stable_d     = stable_q;
        onehot_d     = onehot_q;
        pulse_d      = 1'b0;
        w_commit     = KEY_NONE;
        w_sample     = (slot_q == SLOT_LAST);

        // Current frame with the active column's four bits taken from this cycle's rows
        w_full = frame_q;
        w_full[{col_q, 2'b00} +: 4] = ~w_row_sync;

        slot_d = w_sample ? '0 : slot_q + 1'b1;

        if (w_sample) begin
            frame_d = w_full;
            col_d   = col_q + 2'd1;
            col_n_d = {col_n_q[2:0], col_n_q[3]};

            if (col_q == 2'd3) begin
                last_frame_d = w_full;
                if (w_full == last_frame_q) begin
                    if (stable_q != STAB_MAX) begin
                        stable_d = stable_q + 1'b1;
                    end
                    // Commit exactly once, on the frame that reaches the threshold
                    if (stable_q == STAB_ARM) begin
                        w_commit = is_single_key(w_full) ? w_full : KEY_NONE;
                        onehot_d = w_commit;
                        pulse_d  = (w_commit != KEY_NONE) && (w_commit != onehot_q);
                    end
                end else begin
                    stable_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            col_q        <= 2'd0;
            col_n_q      <= 4'b1110;
            frame_q      <= KEY_NONE;
            last_frame_q <= KEY_NONE;
            stable_q     <= '0;
            onehot_q     <= KEY_NONE;
            pulse_q      <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            col_q        <= col_d;
            col_n_q      <= col_n_d;
            frame_q      <= frame_d;
            last_frame_q <= last_frame_d;
            stable_q     <= stable_d;
            onehot_q     <= onehot_d;
            pulse_q      <= pulse_d;
        end
    end

    assign col_n     = col_n_q;
    assign onehot    = onehot_q;
    assign key_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_matrix_scanner
// Brief   : Self-checking bench for keypad_matrix_scanner (SCAN_DIV=4, 3 frames)
// Revision: 1.0
// ============================================================================
module tb_keypad_matrix_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] onehot;
    logic        key_pulse;
    logic [15:0] keys;

    typedef struct packed {
        logic [15:0] keys;
        logic [15:0] oh;
        logic        p;
    } vec_t;

    typedef struct packed {
        logic [15:0] oh;
        logic        p;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          checks;
    int          errors;
    int          cyc;
    logic [15:0] hold_oh;
    logic [3:0]  c_cols [4];

    keypad_matrix_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .onehot    (onehot),
        .key_pulse (key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Membrane matrix: a pressed key shorts its row to its column
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] k, input logic r, input logic [15:0] eo, input logic ep);
        exp_t e;
        keys = k;
        rst  = r;
        e.oh = eo;
        e.p  = ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc = r ? 0 : cyc + 1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk("onehot", onehot, e.oh);
            chk("key_pulse", 16'(key_pulse), 16'(e.p));
            chk("col_n", 16'(col_n), 16'(c_cols[(cyc / 4) % 4]));
        end
    endtask

    task automatic run_frame(input logic [15:0] k, input logic [15:0] eo, input logic ep);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) step(k, 1'b0, hold_oh, 1'b0);
            else        step(k, 1'b0, eo, ep);
        end
        hold_oh = eo;
    endtask

    task automatic add(input logic [15:0] k, input logic [15:0] o, input logic p, input int n);
        vec_t v;
        v.keys = k;
        v.oh   = o;
        v.p    = p;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        hold_oh = 16'h0000;
        keys    = 16'h0000;
        rst     = 1'b1;
        c_cols  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Idle, clean press (c1,r2), release
        add(16'h0000, 16'h0000, 1'b0, 1);
        add(16'h0040, 16'h0000, 1'b0, 2);
        add(16'h0040, 16'h0040, 1'b1, 1);
        add(16'h0040, 16'h0040, 1'b0, 2);
        add(16'h0000, 16'h0040, 1'b0, 2);
        add(16'h0000, 16'h0000, 1'b0, 2);
        // Two keys rejected, then release (c3,r3), then key-to-key, then release
        add(16'h8001, 16'h0000, 1'b0, 5);
        add(16'h0001, 16'h0000, 1'b0, 2);
        add(16'h0001, 16'h0001, 1'b1, 1);
        add(16'h0040, 16'h0001, 1'b0, 2);
        add(16'h0040, 16'h0040, 1'b1, 1);
        add(16'h0000, 16'h0040, 1'b0, 2);
        add(16'h0000, 16'h0000, 1'b0, 1);

        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1, 16'h0000, 1'b0);

        foreach (tbl[i]) run_frame(tbl[i].keys, tbl[i].oh, tbl[i].p);

        // Bounce every 10 clk, last toggle at clk 60; commit at frame end 111
        for (int j = 0; j < 128; j++) begin
            step((j >= 60 || ((j / 10) % 2) == 0) ? 16'h0040 : 16'h0000, 1'b0,
                 (j >= 111) ? 16'h0040 : 16'h0000, (j == 111));
        end
        hold_oh = 16'h0040;

        // Key stable two frames, reset lands in column 2 of the committing frame
        run_frame(16'h0001, 16'h0040, 1'b0);
        run_frame(16'h0001, 16'h0040, 1'b0);
        for (int j = 0; j < 8; j++) step(16'h0001, 1'b0, 16'h0040, 1'b0);
        chk("col_before_rst", 16'(col_n), 16'(4'b1011));
        for (int j = 0; j < 2; j++) step(16'h0001, 1'b1, 16'h0000, 1'b0);
        hold_oh = 16'h0000;
        run_frame(16'h0001, 16'h0000, 1'b0);
        run_frame(16'h0001, 16'h0000, 1'b0);
        run_frame(16'h0001, 16'h0001, 1'b1);
        step(16'h0001, 1'b0, 16'h0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
